// File: rtl/axis_probe_driver.sv
// rtl/axis_probe_driver.sv - serialize a stimulus vector to AXIS, collect the AXIS response into a flat vector (optional watchdog: AXIS_PROBE_DRV_TIMEOUT_EN)
module axis_probe_driver #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int VIP2DUT_WORDS_NUM = 10,
    parameter int DUT2VIP_WORDS_NUM = 10,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                      s_axis_aclk,
    input  logic                                      s_axis_areset,
    input  logic                                      stim_valid,
    output logic                                      stim_ready,
    input  logic [C_DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0] stim_data,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]                   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]                 m_axis_tkeep,
    output logic                                      m_axis_tlast,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]                   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]                 s_axis_tkeep,
    input  logic                                      s_axis_tlast,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0] resp_data,
    output logic                                      resp_err,
    output logic                                      resp_timeout,
    output logic                                      busy
);

    localparam int W   = C_DATA_WIDTH;
    localparam int TXW = $clog2(VIP2DUT_WORDS_NUM) + 1;
    localparam int RXW = $clog2(DUT2VIP_WORDS_NUM) + 1;
    localparam logic [TXW-1:0] TX_LAST = TXW'(VIP2DUT_WORDS_NUM - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(DUT2VIP_WORDS_NUM - 1);
    localparam logic [RXW-1:0] RX_FULL = RXW'(DUT2VIP_WORDS_NUM);

    typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;

    state_t                       state, state_nxt;
    logic [W*VIP2DUT_WORDS_NUM-1:0] stim_reg;
    logic [TXW-1:0]               tx_cnt;
    logic [RXW-1:0]               rx_cnt;
    logic                         err_reg;
    logic                         wd_expired;
    logic                         stim_hs, m_hs, s_hs;

    assign stim_hs      = (state == IDLE) && stim_valid;
    assign m_hs         = (state == SEND) && m_axis_tready;
    assign s_hs         = s_axis_tready && s_axis_tvalid;
    assign m_axis_tdata = stim_reg[W*VIP2DUT_WORDS_NUM-1 -: W];
    assign m_axis_tkeep = '1;
    assign resp_err     = err_reg;

`ifdef AXIS_PROBE_DRV_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);

    logic [WDW-1:0] wd_cnt;
    logic           timeout_reg;

    assign wd_expired   = (state == RECV) && (wd_cnt == WD_LIMIT);
    assign resp_timeout = timeout_reg;

    // Idle-cycle watchdog: counts RECV cycles without a beat, clears on every beat.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            wd_cnt      <= '0;
            timeout_reg <= 1'b0;
        end else if (stim_hs) begin
            wd_cnt      <= '0;
            timeout_reg <= 1'b0;
        end else if (state == RECV) begin
            if (wd_expired)
                timeout_reg <= 1'b1;
            else if (s_hs)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign wd_expired     = 1'b0;
    assign resp_timeout   = 1'b0;
`endif

    logic unused_keep;
    assign unused_keep = &{1'b0, s_axis_tkeep};

    // State register.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs; the beat that expires the watchdog is not accepted.
    always_comb begin
        state_nxt     = state;
        stim_ready    = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        resp_valid    = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                stim_ready = 1'b1;
                busy       = 1'b0;
                if (stim_valid)
                    state_nxt = SEND;
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (tx_cnt == TX_LAST);
                if (m_axis_tready && (tx_cnt == TX_LAST))
                    state_nxt = RECV;
            end
            RECV: begin
                s_axis_tready = !wd_expired;
                if (wd_expired)
                    state_nxt = RESP;
                else if (s_axis_tvalid && s_axis_tlast)
                    state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: stimulus shifter, response word writer, counters and length-error flag.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            stim_reg  <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            resp_data <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (stim_hs) begin
                stim_reg <= stim_data;
                tx_cnt   <= '0;
                rx_cnt   <= '0;
                err_reg  <= 1'b0;
            end
            if (m_hs) begin
                stim_reg <= stim_reg << W;
                if (tx_cnt != TX_LAST)
                    tx_cnt <= tx_cnt + 1'b1;
            end
            if (s_hs) begin
                // Beats fill from the top word down; extra beats past the end are dropped.
                for (int k = 0; k < DUT2VIP_WORDS_NUM; k++) begin
                    if (rx_cnt == RXW'(DUT2VIP_WORDS_NUM - 1 - k))
                        resp_data[k*W +: W] <= s_axis_tdata;
                end
                if (rx_cnt != RX_FULL)
                    rx_cnt <= rx_cnt + 1'b1;
                if (s_axis_tlast ? (rx_cnt != RX_LAST) : (rx_cnt >= RX_LAST))
                    err_reg <= 1'b1;
            end
`ifdef AXIS_PROBE_DRV_TIMEOUT_EN
            if (wd_expired)
                err_reg <= 1'b1;
`endif
        end
    end

endmodule
